// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one load/store at a time over the
// req/ok handshake, aligns and extends load data, and traps misaligned accesses.
module mem_access_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [RA_W-1:0]   wa,
   input  logic [XLEN-1:0]   wn,
   input  logic [XLEN-1:0]   sd,
   input  logic [4:0]        op,
   output logic              we_o,
   output logic [RA_W-1:0]   wa_o,
   output logic [XLEN-1:0]   wn_o,
   output logic              exc_o,
   output logic [XLEN-1:0]   exc_a,
   output logic              mct_req,
   output logic              mct_wr,
   output logic [XLEN-1:0]   mct_a,
   output logic [XLEN-1:0]   mct_d,
   output logic [XLEN/8-1:0] mct_be,
   input  logic [XLEN-1:0]   mct_q,
   input  logic              mct_ok,
   output logic              stl
);

   localparam int OFFW = $clog2(XLEN / 8);
   localparam int BE_W = XLEN / 8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, state_nxt;

   logic [OFFW-1:0] off;
   logic [1:0]      size;
   logic            is_mem;
   logic            legal;
   logic [BE_W-1:0] be_base;
   logic [BE_W-1:0] be_new;
   logic [XLEN-1:0] addr_aligned;
   logic [XLEN-1:0] d_new;

   logic            we_l;
   logic [RA_W-1:0] wa_l;
   logic [3:0]      op_l;
   logic [OFFW-1:0] off_l;
   logic [XLEN-1:0] addr_l;

   logic [XLEN-1:0] q_sh;
   logic [XLEN-1:0] keep;
   logic            sign_bit;
   logic [XLEN-1:0] ld_val;

   assign off          = wn[OFFW-1:0];
   assign size         = op[1:0];
   assign is_mem       = op[4];
   assign addr_aligned = {wn[XLEN-1:OFFW], {OFFW{1'b0}}};
   assign d_new        = sd << {off, 3'b000};
   assign be_new       = be_base << off;

   // Alignment check and base byte-enable pattern for the requested size
   always_comb begin
      legal   = 1'b1;
      be_base = '0;
      case (size)
         2'd0: begin
            be_base = BE_W'(1);
         end
         2'd1: begin
            be_base = BE_W'(2'b11);
            legal   = ~off[0];
         end
         2'd2: begin
            be_base = BE_W'(4'hF);
            legal   = (off[1:0] == 2'b00);
         end
         default: begin
            be_base = '1;
            legal   = (XLEN == 64) && (off == '0);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stl       = 1'b0;
      case (state)
         IDLE: begin
            if (is_mem && legal) begin
               stl       = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            stl = ~mct_ok;
            if (mct_ok) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) begin
         stl = 1'b0;
      end
   end

   // Bytes above the access size are replaced by the sign bit or zeros
   always_comb begin
      q_sh     = mct_q >> {off_l, 3'b000};
      keep     = '1;
      sign_bit = q_sh[XLEN-1];
      case (op_l[1:0])
         2'd0: begin
            keep     = XLEN'(8'hFF);
            sign_bit = q_sh[7];
         end
         2'd1: begin
            keep     = XLEN'(16'hFFFF);
            sign_bit = q_sh[15];
         end
         2'd2: begin
            keep     = XLEN'(32'hFFFF_FFFF);
            sign_bit = q_sh[31];
         end
         default: ;
      endcase
      ld_val = (q_sh & keep) | ({XLEN{sign_bit & ~op_l[2]}} & ~keep);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_o    <= 1'b0;
         wa_o    <= '0;
         wn_o    <= '0;
         exc_o   <= 1'b0;
         exc_a   <= '0;
         mct_req <= 1'b0;
         mct_wr  <= 1'b0;
         mct_a   <= '0;
         mct_d   <= '0;
         mct_be  <= '0;
         we_l    <= 1'b0;
         wa_l    <= '0;
         op_l    <= '0;
         off_l   <= '0;
         addr_l  <= '0;
      end else begin
         case (state)
            IDLE: begin
               exc_o <= 1'b0;
               if (!is_mem) begin
                  we_o <= we;
                  wa_o <= wa;
                  wn_o <= wn;
               end else if (!legal) begin
                  we_o  <= 1'b0;
                  exc_o <= 1'b1;
                  exc_a <= wn;
               end else begin
                  mct_req <= 1'b1;
                  mct_wr  <= op[3];
                  mct_a   <= addr_aligned;
                  mct_be  <= be_new;
                  mct_d   <= d_new;
                  we_l    <= we;
                  wa_l    <= wa;
                  op_l    <= op[3:0];
                  off_l   <= off;
                  addr_l  <= wn;
                  we_o    <= 1'b0;
               end
            end
            BUSY: begin
               // Write-back uses the latched copies, not the upstream inputs
               if (mct_ok) begin
                  mct_req <= 1'b0;
                  if (op_l[3]) begin
                     we_o <= 1'b0;
                     wn_o <= addr_l;
                  end else begin
                     we_o <= we_l;
                     wa_o <= wa_l;
                     wn_o <= ld_val;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases on XLEN=32 and 64,
// then randomized traffic on XLEN=32 compared each cycle against a reference model.
module tb_mem_access_stage;

   logic clk;
   logic rst;

   logic        we;
   logic [4:0]  wa;
   logic [31:0] wn;
   logic [31:0] sd;
   logic [4:0]  op;
   logic        we_o;
   logic [4:0]  wa_o;
   logic [31:0] wn_o;
   logic        exc_o;
   logic [31:0] exc_a;
   logic        mct_req;
   logic        mct_wr;
   logic [31:0] mct_a;
   logic [31:0] mct_d;
   logic [3:0]  mct_be;
   logic [31:0] mct_q;
   logic        mct_ok;
   logic        stl;

   logic        we64;
   logic [4:0]  wa64;
   logic [63:0] wn64;
   logic [63:0] sd64;
   logic [4:0]  op64;
   logic        we_o64;
   logic [4:0]  wa_o64;
   logic [63:0] wn_o64;
   logic        exc_o64;
   logic [63:0] exc_a64;
   logic        mct_req64;
   logic        mct_wr64;
   logic [63:0] mct_a64;
   logic [63:0] mct_d64;
   logic [7:0]  mct_be64;
   logic [63:0] mct_q64;
   logic        mct_ok64;
   logic        stl64;

   int total = 0;
   int bad   = 0;

   // Reference model state for the XLEN=32 instance
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wn;
   logic        m_exc;
   logic [31:0] m_exc_a;
   logic        m_req;
   logic        m_wr;
   logic [31:0] m_a;
   logic [31:0] m_d;
   logic [3:0]  m_be;
   bit          pend    = 0;
   bit          started = 0;
   logic        p_we;
   logic [4:0]  p_wa;
   logic [4:0]  p_op;
   logic [31:0] p_addr;
   int          wait_cnt = 0;

   mem_access_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wn(wn), .sd(sd), .op(op),
      .we_o(we_o), .wa_o(wa_o), .wn_o(wn_o), .exc_o(exc_o), .exc_a(exc_a),
      .mct_req(mct_req), .mct_wr(mct_wr), .mct_a(mct_a), .mct_d(mct_d),
      .mct_be(mct_be), .mct_q(mct_q), .mct_ok(mct_ok), .stl(stl)
   );

   mem_access_stage #(.XLEN(64), .RA_W(5)) dut64 (
      .clk(clk), .rst(rst), .we(we64), .wa(wa64), .wn(wn64), .sd(sd64), .op(op64),
      .we_o(we_o64), .wa_o(wa_o64), .wn_o(wn_o64), .exc_o(exc_o64), .exc_a(exc_a64),
      .mct_req(mct_req64), .mct_wr(mct_wr64), .mct_a(mct_a64), .mct_d(mct_d64),
      .mct_be(mct_be64), .mct_q(mct_q64), .mct_ok(mct_ok64), .stl(stl64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit illegal_op(int xlen, logic [63:0] addr, logic [4:0] o);
      int n;
      n = 1 << o[1:0];
      if (o[1:0] == 2'd3 && xlen == 32) return 1'b1;
      return (addr % 64'(n)) != 64'd0;
   endfunction

   function automatic logic [63:0] load_model(logic [63:0] q, int off, logic [4:0] o);
      int nb;
      logic [63:0] mask;
      logic [63:0] v;
      nb   = 8 << o[1:0];
      v    = q >> (8 * off);
      mask = (nb >= 64) ? '1 : ((64'd1 << nb) - 64'd1);
      v    = v & mask;
      if (!o[2] && (((v >> (nb - 1)) & 64'd1) != 64'd0)) v = v | ~mask;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] n,
                                input logic [31:0] d, input logic [4:0] o);
      we = w;
      wa = a;
      wn = n;
      sd = d;
      op = o;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_we = 0; m_wa = 0; m_wn = 0; m_exc = 0; m_exc_a = 0;
         m_req = 0; m_wr = 0; m_a = 0; m_d = 0; m_be = 0;
         pend = 0;
         started = 1;
      end else if (!pend) begin
         m_exc = 0;
         if (!op[4]) begin
            m_we = we;
            m_wa = wa;
            m_wn = wn;
         end else if (illegal_op(32, 64'(wn), op)) begin
            m_we    = 0;
            m_exc   = 1;
            m_exc_a = wn;
         end else begin : issue
            int off;
            off    = int'(wn % 32'd4);
            m_req  = 1;
            m_wr   = op[3];
            m_a    = wn - 32'(off);
            m_be   = 4'(((1 << (1 << op[1:0])) - 1) << off);
            m_d    = 32'(64'(sd) << (8 * off));
            p_we   = we;
            p_wa   = wa;
            p_op   = op;
            p_addr = wn;
            m_we   = 0;
            pend   = 1;
         end
      end else if (mct_ok) begin
         m_req = 0;
         pend  = 0;
         if (p_op[3]) begin
            m_we = 0;
            m_wn = p_addr;
         end else begin
            m_wn = 32'(load_model(64'(mct_q), int'(p_addr % 32'd4), p_op));
            m_we = p_we;
            m_wa = p_wa;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin : cmp
         logic e_stl;
         e_stl = rst ? 1'b0 : (pend ? !mct_ok : (op[4] && !illegal_op(32, 64'(wn), op)));
         checkOutput("stl", 64'(stl), 64'(e_stl));
         checkOutput("we_o", 64'(we_o), 64'(m_we));
         checkOutput("wa_o", 64'(wa_o), 64'(m_wa));
         checkOutput("wn_o", 64'(wn_o), 64'(m_wn));
         checkOutput("exc_o", 64'(exc_o), 64'(m_exc));
         checkOutput("mct_req", 64'(mct_req), 64'(m_req));
         if (m_exc) checkOutput("exc_a", 64'(exc_a), 64'(m_exc_a));
         if (m_req) begin
            checkOutput("mct_wr", 64'(mct_wr), 64'(m_wr));
            checkOutput("mct_a", 64'(mct_a), 64'(m_a));
            checkOutput("mct_d", 64'(mct_d), 64'(m_d));
            checkOutput("mct_be", 64'(mct_be), 64'(m_be));
         end
      end
   end

   initial begin
      rst = 1;
      mct_ok = 0; mct_q = 0;
      applyStimulus(0, 0, 0, 0, 0);
      we64 = 0; wa64 = 0; wn64 = 0; sd64 = 0; op64 = 0; mct_ok64 = 0; mct_q64 = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;

      applyStimulus(1, 5'd3, 32'h1234, 0, 5'b00000);
      @(negedge clk); checkOutput("pt_stl", 64'(stl), 64'd0);
      nextCycle();
      checkOutput("pt_we", 64'(we_o), 64'd1);
      checkOutput("pt_wa", 64'(wa_o), 64'd3);
      checkOutput("pt_wn", 64'(wn_o), 64'h1234);

      applyStimulus(1, 5'd7, 32'h1003, 0, 5'b10000);
      @(negedge clk); checkOutput("ldb_stl0", 64'(stl), 64'd1);
      nextCycle();
      checkOutput("ldb_req", 64'(mct_req), 64'd1);
      checkOutput("ldb_addr", 64'(mct_a), 64'h1000);
      checkOutput("ldb_be", 64'(mct_be), 64'b1000);
      checkOutput("ldb_bubble", 64'(we_o), 64'd0);
      @(negedge clk); checkOutput("ldb_stl1", 64'(stl), 64'd1);
      nextCycle();
      @(negedge clk); checkOutput("ldb_stl2", 64'(stl), 64'd1);
      nextCycle();
      mct_ok = 1; mct_q = 32'h80FF_FFFF;
      @(negedge clk); checkOutput("ldb_stl3", 64'(stl), 64'd0);
      nextCycle();
      mct_ok = 0;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("ldb_wn", 64'(wn_o), 64'hFFFF_FF80);
      checkOutput("ldb_we", 64'(we_o), 64'd1);
      checkOutput("ldb_wa", 64'(wa_o), 64'd7);
      checkOutput("ldb_req_drop", 64'(mct_req), 64'd0);

      applyStimulus(1, 5'd9, 32'h2002, 0, 5'b10101);
      nextCycle();
      checkOutput("ldh_be", 64'(mct_be), 64'b1100);
      checkOutput("ldh_addr", 64'(mct_a), 64'h2000);
      mct_ok = 1; mct_q = 32'h8001_0000;
      nextCycle();
      mct_ok = 0;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("ldhu_wn", 64'(wn_o), 64'h0000_8001);
      checkOutput("ldhu_we", 64'(we_o), 64'd1);

      applyStimulus(1, 5'd4, 32'h3001, 32'hAB, 5'b11000);
      nextCycle();
      checkOutput("sb_wr", 64'(mct_wr), 64'd1);
      checkOutput("sb_be", 64'(mct_be), 64'b0010);
      checkOutput("sb_d", 64'(mct_d), 64'h0000_AB00);
      mct_ok = 1; mct_q = 32'hDEAD_BEEF;
      nextCycle();
      mct_ok = 0;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("sb_we", 64'(we_o), 64'd0);
      checkOutput("sb_wn", 64'(wn_o), 64'h3001);

      applyStimulus(1, 5'd2, 32'h4002, 0, 5'b10010);
      @(negedge clk); checkOutput("mis_stl", 64'(stl), 64'd0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("mis_exc", 64'(exc_o), 64'd1);
      checkOutput("mis_exc_a", 64'(exc_a), 64'h4002);
      checkOutput("mis_we", 64'(we_o), 64'd0);
      checkOutput("mis_req", 64'(mct_req), 64'd0);
      nextCycle();
      checkOutput("mis_exc_once", 64'(exc_o), 64'd0);

      applyStimulus(1, 5'd6, 32'h5000, 0, 5'b10010);
      nextCycle();
      checkOutput("rb_req", 64'(mct_req), 64'd1);
      rst = 1;
      @(negedge clk); checkOutput("rb_stl_rst", 64'(stl), 64'd0);
      nextCycle();
      rst = 0;
      mct_ok = 1; mct_q = 32'h1234_5678;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("rb_req0", 64'(mct_req), 64'd0);
      checkOutput("rb_a0", 64'(mct_a), 64'd0);
      checkOutput("rb_be0", 64'(mct_be), 64'd0);
      @(negedge clk); checkOutput("rb_stl_stray", 64'(stl), 64'd0);
      nextCycle();
      mct_ok = 0;
      checkOutput("rb_we", 64'(we_o), 64'd0);
      checkOutput("rb_wn", 64'(wn_o), 64'd0);
      checkOutput("rb_wa", 64'(wa_o), 64'd0);
      checkOutput("rb_req1", 64'(mct_req), 64'd0);

      we64 = 1; wa64 = 5'd11; wn64 = 64'h8; sd64 = 64'h1122_3344_5566_7788; op64 = 5'b10011;
      @(negedge clk); checkOutput("d64_stl0", 64'(stl64), 64'd1);
      nextCycle();
      checkOutput("d64_be", 64'(mct_be64), 64'hFF);
      checkOutput("d64_addr", mct_a64, 64'h8);
      checkOutput("d64_req", 64'(mct_req64), 64'd1);
      checkOutput("d64_wr", 64'(mct_wr64), 64'd0);
      checkOutput("d64_d", mct_d64, 64'h1122_3344_5566_7788);
      mct_ok64 = 1; mct_q64 = 64'h8000_0000_0000_0001;
      @(negedge clk); checkOutput("d64_stl1", 64'(stl64), 64'd0);
      nextCycle();
      mct_ok64 = 0; we64 = 0; op64 = 0; wn64 = 0;
      checkOutput("d64_wn", wn_o64, 64'h8000_0000_0000_0001);
      checkOutput("d64_we", 64'(we_o64), 64'd1);
      checkOutput("d64_wa", 64'(wa_o64), 64'd11);

      we64 = 1; wa64 = 5'd12; wn64 = 64'hC; op64 = 5'b10010;
      nextCycle();
      checkOutput("w64_be", 64'(mct_be64), 64'hF0);
      checkOutput("w64_addr", mct_a64, 64'h8);
      mct_ok64 = 1; mct_q64 = 64'h8000_0001_1234_5678;
      nextCycle();
      mct_ok64 = 0; we64 = 0; op64 = 0; wn64 = 0;
      checkOutput("w64_wn", wn_o64, 64'hFFFF_FFFF_8000_0001);

      we64 = 1; wn64 = 64'h4; op64 = 5'b10011;
      @(negedge clk); checkOutput("m64_stl", 64'(stl64), 64'd0);
      nextCycle();
      we64 = 0; op64 = 0; wn64 = 0;
      checkOutput("m64_exc", 64'(exc_o64), 64'd1);
      checkOutput("m64_exc_a", exc_a64, 64'h4);
      checkOutput("m64_req", 64'(mct_req64), 64'd0);

      for (int c = 0; c < 3000; c++) begin
         rst = 0;
         if (pend) begin
            mct_ok = (wait_cnt == 0);
            mct_q  = $urandom();
            if (wait_cnt > 0) wait_cnt--;
            if ($urandom_range(0, 99) == 0) rst = 1;
         end else begin
            mct_ok = ($urandom_range(0, 7) == 0);
            mct_q  = $urandom();
            if ($urandom_range(0, 59) == 0) rst = 1;
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom());
            sd = $urandom();
            wn = $urandom();
            if ($urandom_range(0, 1) == 1) wn = wn & ~32'h3;
            op = 5'($urandom());
            op[4] = ($urandom_range(0, 3) != 0);
            wait_cnt = $urandom_range(0, 3);
         end
         nextCycle();
      end

      rst = 0;
      mct_ok = 0;
      applyStimulus(0, 0, 0, 0, 0);
      repeat (6) nextCycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage for the RISC-V core, placed between execute and write-back. It performs loads and stores of byte, half, word and (XLEN=64 only) doubleword size through the memory-controller request/acknowledge handshake. Sub-word data is lane-aligned and sign- or zero-extended. A combinational stall holds upstream stages while an access is outstanding. The stage traps misaligned accesses and passes non-memory results through to write-back via a register.

## Interface
Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- RA_W, 5, register-address width.
- OFFW, log2(XLEN/8), byte-offset bits (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- we  in  1  register write enable from execute.
- wa  in  RA_W  destination register.
- wn  in  XLEN  ALU result: the effective address for memory ops, otherwise the result.
- sd  in  XLEN  store data; the low bytes are significant.
- op  in  5  bit [4] memory access, bit [3] store, bit [2] unsigned load, bits [1:0] size: 0 byte, 1 half, 2 word, 3 dword.
- we_o  out  1  registered write enable to write-back.
- wa_o  out  RA_W  registered destination register.
- wn_o  out  XLEN  registered write-back data.
- exc_o  out  1  registered one-cycle misaligned/illegal-access flag.
- exc_a  out  XLEN  faulting address, valid while exc_o=1.
- mct_req  out  1  memory request.
- mct_wr  out  1  1 = write.
- mct_a  out  XLEN  aligned address, wn with the low OFFW bits cleared.
- mct_d  out  XLEN  lane-shifted store data.
- mct_be  out  XLEN/8  byte enables.
- mct_q  in  XLEN  read data; full aligned word.
- mct_ok  in  1  one-cycle acknowledge.
- stl  out  1  combinational stall to upstream stages.

## Operation
- FSM states: IDLE and BUSY.
- Offset: off = wn[OFFW-1:0]. Size bytes: n = 1 << op[1:0].
- An access is illegal when off is not a multiple of n, or when size=3 and XLEN=32.
- IDLE, no memory op (op[4]=0):
  - At the clock edge, we_o/wa_o/wn_o load we/wa/wn and exc_o loads 0.
  - stl=0.
- IDLE, illegal memory op:
  - No request is issued; stl=0.
  - At the edge, we_o loads 0, exc_o loads 1, exc_a loads wn.
- IDLE, legal memory op:
  - stl=1.
  - At the edge: mct_req=1, mct_wr=op[3], mct_a as defined above.
  - mct_be has bits [off+n-1:off] set and all other bits clear.
  - mct_d = sd shifted left by 8*off.
  - The block latches wa, op, off and we internally; state goes to BUSY.
  - we_o drops to 0 for this edge (a bubble).
- BUSY:
  - stl = ~mct_ok. Request outputs are held stable.
  - On mct_ok: mct_req goes to 0 and state goes to IDLE.
  - Load on mct_ok: the data field is mct_q >> 8*off, truncated to n bytes, then sign-extended (op[2]=0) or zero-extended (op[2]=1) to XLEN. The result loads into wn_o, we_o loads the latched we, and wa_o loads the latched wa.
  - Store on mct_ok: we_o loads 0 and wn_o loads the address.
- mct_ok while IDLE is ignored.
- Only one access is outstanding at a time.
- Reset:
  - Every output register clears: we_o=0, wa_o=0, wn_o=0, exc_o=0, exc_a=0, mct_req=0, mct_wr=0, mct_a=0, mct_d=0, mct_be=0. State goes to IDLE.
  - Reset during BUSY abandons the access. An mct_ok arriving after reset is ignored.
- stl is 0 while rst=1.

## Timing
- Non-memory op and illegal op: 1-cycle latency, no stall.
- Memory op presented in cycle 0: stl=1 in cycle 0, and mct_req rises at the end of cycle 0.
- If mct_ok arrives in cycle k≥1:
  - stl is high in cycles 0..k-1 and 0 in cycle k.
  - Write-back outputs update at the end of cycle k, the same edge at which upstream advances.
  - The next op is accepted in cycle k+1.
- Minimum load-to-write-back latency: 2 cycles; 1 stall cycle.
- Upstream holds we/wa/wn/sd/op stable while stl=1. The block still uses its latched copies for write-back.
- Back-to-back memory ops: the second op's request rises at the end of cycle k+1.

## Test plan
- XLEN=32, pass-through: op=0, we=1, wa=3, wn=0x1234 → next edge we_o=1, wa_o=3, wn_o=0x1234, stl never asserted.
- Signed byte load: wn=0x1003, op=5'b10000, mct_ok in cycle 3 with mct_q=0x80FFFFFF → mct_a=0x1000, mct_be=4'b1000, stl high cycles 0-2, wn_o=0xFFFFFF80, we_o=1.
- Unsigned half load: wn=0x2002, op=5'b10101, mct_q=0x8001_0000 → mct_be=4'b1100, wn_o=0x00008001.
- Byte store: wn=0x3001, sd=0xAB, op=5'b11000 → mct_wr=1, mct_be=4'b0010, mct_d=0x0000AB00, we_o=0 after ack.
- Misaligned word load: wn=0x4002, op=5'b10010 → mct_req stays 0, exc_o=1 for one cycle, exc_a=0x4002, we_o=0.
- Reset while BUSY, then a stray mct_ok: mct_req=0 and stl=0 after the reset edge, and all outputs stay at reset values. Then rerun in XLEN=64 with a dword load at 0x8, mct_q=0x8000_0000_0000_0001 → wn_o equals mct_q and mct_be=8'hFF.
